delay_scheduler: RTL and testbench

Shares one millisecond countdown engine among up to N_REQ requesters (digit-advance tick, display blink, key debounce) in the BCD counter / dual seven-segment design. Requesters post a delay length; the block grants them round-robin, counts the delay on the 1 kHz system clock, and returns a one-cycle done pulse to the owning requester. It replaces per-function delay counters with a single sequenced resource.

---
 rtl/delay_sched_pkg.sv | 17 +
 rtl/delay_scheduler_rr_pick.sv | 34 +++
 rtl/delay_scheduler.sv | 113 +++++++++++
 tb/tb_delay_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_sched_pkg.sv
// Shared types and defaults for the delay scheduler: FSM states, default sizes,
// and the owner-index width helper.
package delay_sched_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 9;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int owner_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/delay_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping, returned as one-hot, index and valid.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic [IW-1:0] idx_o,
    output logic          vld_o
);

    int  j;
    logic found;

    always_comb begin
        win_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                win_o[j] = 1'b1;
                idx_o    = IW'(j);
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/delay_scheduler.sv
// One shared millisecond countdown engine, granted round-robin to N_REQ requesters.
// Optional per-requester cancel is built when DLY_SCHED_ABORT_EN is defined.
module delay_scheduler
    import delay_sched_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    parameter  int CNT_W = CNT_W_DEF,
    localparam int OW    = owner_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] dly,
`ifdef DLY_SCHED_ABORT_EN
    input  logic [N_REQ-1:0]       abort,
`endif
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic [OW-1:0]          owner,
    output logic [CNT_W-1:0]       remaining
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] done_q, done_d;

    logic [N_REQ-1:0] pick_oh;
    logic [OW-1:0]    pick_idx;
    logic             pick_vld;
    logic [CNT_W-1:0] dly_sel;

    rr_pick #(
        .N  (N_REQ),
        .IW (OW)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (pick_oh),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    assign dly_sel = dly[int'(pick_idx)*CNT_W +: CNT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = '0;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = RUN;
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    ptr_d   = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + OW'(1);
                    // A zero-length delay still occupies the engine for one cycle.
                    cnt_d   = (dly_sel == '0) ? CNT_W'(1) : dly_sel;
                end
            end
            RUN: begin
`ifdef DLY_SCHED_ABORT_EN
                if (abort[owner_q]) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else
`endif
                if (cnt_q <= CNT_W'(1)) begin
                    state_d         = IDLE;
                    cnt_d           = '0;
                    done_d[owner_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = (state_q == RUN);
    assign owner     = owner_q;
    assign remaining = cnt_q;

endmodule

// File: tb/tb_delay_scheduler.sv
// Directed bench for delay_scheduler: scoreboard of expected grants (index, delay,
// cycle) checked by a monitor, plus directed busy/remaining/reset/abort checks.
module tb_delay_scheduler;

    localparam int N_REQ = 4;
    localparam int CNT_W = 9;
    localparam int OW    = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*CNT_W-1:0] dly;
    logic [N_REQ-1:0]       abort;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [OW-1:0]          owner;
    logic [CNT_W-1:0]       remaining;

    typedef struct {
        int idx;
        int d;
        int cyc;
    } exp_t;

    exp_t gq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   pend_idx = -1;
    int   pend_cyc = -1;
    int   abort_cnt = 0;
    int   abort_seen = 0;
    int   c0;

    always #5 clk = ~clk;

    delay_scheduler #(
        .N_REQ (N_REQ),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .dly       (dly),
`ifdef DLY_SCHED_ABORT_EN
        .abort     (abort),
`endif
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .owner     (owner),
        .remaining (remaining)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_dly(input int idx, input int val);
        dly[idx*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    task automatic wait_grant(input int idx, input bit drop);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (grant[idx] !== 1'b1 && n < 2000);
        chk($sformatf("grant_wait%0d", idx), 32'(grant[idx]), 32'd1);
        if (drop) req[idx] = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((busy !== 1'b0 || gq.size() != 0 || pend_cyc >= 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(n < budget), 32'd1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (rst) begin
            pend_idx = -1;
            pend_cyc = -1;
        end else begin
            if (abort_cnt != abort_seen) begin
                abort_seen = abort_cnt;
                pend_idx   = -1;
                pend_cyc   = -1;
            end
            chk("grant_done_overlap", 32'((grant != 0) && (done != 0)), 32'd0);
            if (grant != 0) begin
                if (gq.size() == 0) begin
                    chk("grant_unexpected", 32'(grant), 32'd0);
                end else begin
                    e = gq.pop_front();
                    chk("grant_idx", 32'(grant), 32'(1 << e.idx));
                    chk("grant_cyc", 32'(cyc), 32'(e.cyc));
                    pend_idx = e.idx;
                    pend_cyc = cyc + ((e.d == 0) ? 1 : e.d);
                end
            end
            if (done != 0) begin
                chk("done_idx", 32'(done), (pend_idx < 0) ? 32'd0 : 32'(1 << pend_idx));
                chk("done_cyc", 32'(cyc), 32'(pend_cyc));
                pend_idx = -1;
                pend_cyc = -1;
            end else if (pend_cyc >= 0 && cyc >= pend_cyc) begin
                chk("done_missing", 32'(done), 32'(1 << pend_idx));
                pend_idx = -1;
                pend_cyc = -1;
            end
        end
    end

    initial begin
        rst   = 1'b1;
        req   = '0;
        dly   = '0;
        abort = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_remaining", 32'(remaining), 32'd0);
        rst = 1'b0;

        // Single request, delay 5.
        @(negedge clk);
        set_dly(0, 5);
        gq.push_back('{0, 5, cyc + 1});
        req[0] = 1'b1;
        wait_grant(0, 1'b1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_owner", 32'(owner), 32'd0);
        chk("t1_rem0", 32'(remaining), 32'd5);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t1_rem%0d", k), 32'(remaining), 32'(5 - k));
            chk("t1_busy_run", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_rem_end", 32'(remaining), 32'd0);
        wait_drain(50);

        // All four requesting together, delay 3 each: strict 0,1,2,3 every 4 cycles.
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_dly(i, 3);
        c0 = cyc;
        for (int i = 0; i < N_REQ; i++) gq.push_back('{i, 3, c0 + 1 + 4*i});
        req = 4'b1111;
        for (int i = 0; i < N_REQ; i++) wait_grant(i, 1'b1);
        wait_drain(50);

        // req[1] held, req[2] arrives while 1 runs: order 1, 2, 1.
        do_reset();
        set_dly(1, 5);
        set_dly(2, 4);
        c0 = cyc;
        gq.push_back('{1, 5, c0 + 1});
        req[1] = 1'b1;
        wait_grant(1, 1'b0);
        @(negedge clk);
        req[2] = 1'b1;
        gq.push_back('{2, 4, c0 + 7});
        gq.push_back('{1, 5, c0 + 12});
        wait_grant(2, 1'b1);
        wait_grant(1, 1'b1);
        wait_drain(50);

        // Zero-length delay, then the maximum length.
        set_dly(0, 0);
        gq.push_back('{0, 0, cyc + 1});
        req[0] = 1'b1;
        wait_grant(0, 1'b1);
        chk("t4_rem_zero", 32'(remaining), 32'd1);
        @(negedge clk);
        chk("t4_done_zero", 32'(done), 32'd1);
        wait_drain(20);
        set_dly(0, 511);
        gq.push_back('{0, 511, cyc + 1});
        req[0] = 1'b1;
        wait_grant(0, 1'b1);
        chk("t4_rem_max", 32'(remaining), 32'd511);
        wait_drain(600);

        // Asynchronous reset mid-delay; pointer must restart from 0.
        do_reset();
        set_dly(1, 300);
        gq.push_back('{1, 300, cyc + 1});
        req[1] = 1'b1;
        wait_grant(1, 1'b1);
        repeat (100) @(negedge clk);
        chk("t5_rem200", 32'(remaining), 32'd200);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_owner", 32'(owner), 32'd0);
        chk("t5_rst_remaining", 32'(remaining), 32'd0);
        chk("t5_rst_grant", 32'(grant), 32'd0);
        chk("t5_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (310) @(negedge clk);
        set_dly(1, 2);
        set_dly(3, 2);
        c0 = cyc;
        gq.push_back('{1, 2, c0 + 1});
        gq.push_back('{3, 2, c0 + 4});
        req = 4'b1010;
        wait_grant(1, 1'b1);
        wait_grant(3, 1'b1);
        wait_drain(50);

`ifdef DLY_SCHED_ABORT_EN
        // Abort: non-owner ignored, owner cancels with no done; pointer kept.
        do_reset();
        set_dly(2, 30);
        gq.push_back('{2, 30, cyc + 1});
        req[2] = 1'b1;
        wait_grant(2, 1'b1);
        repeat (20) @(negedge clk);
        chk("t6_rem10", 32'(remaining), 32'd10);
        abort = 4'b0001;
        @(negedge clk);
        abort = '0;
        chk("t6_nonowner_busy", 32'(busy), 32'd1);
        chk("t6_nonowner_rem", 32'(remaining), 32'd9);
        abort = 4'b0100;
        abort_cnt++;
        @(negedge clk);
        abort = '0;
        chk("t6_abort_busy", 32'(busy), 32'd0);
        chk("t6_abort_rem", 32'(remaining), 32'd0);
        chk("t6_abort_done", 32'(done), 32'd0);
        repeat (15) @(negedge clk);
        set_dly(0, 2);
        set_dly(2, 2);
        c0 = cyc;
        gq.push_back('{0, 2, c0 + 1});
        gq.push_back('{2, 2, c0 + 4});
        req = 4'b0101;
        wait_grant(0, 1'b1);
        wait_grant(2, 1'b1);
        wait_drain(50);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
